// File: rtl/hazard_stall_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_stall_ctrl
//
// Pipeline sequencing controller for the 5-stage 16-bit core. Decides, every
// cycle, which pipeline registers capture, which get cleared to a bubble and
// whether the PC advances. Four things can interrupt normal flow:
//   - a fixed-latency data-memory access freezes the whole pipeline,
//   - a load followed by a dependent instruction injects one bubble,
//   - a taken branch resolved in ID squashes the wrong-path fetch,
//   - HLT stops fetch, lets older instructions drain, then parks the core.
// Also keeps a saturating count of cycles where the PC did not advance.
//
// Parameters:
//   MEM_LAT  data-memory latency in cycles (>=1), 1 = never freezes
//   REG_W    register index width
//   DRAIN    cycles after HLT leaves ID before halted asserts
//
// Ports:
//   clk, rst               clock (rising edge), synchronous active-low reset
//   id_rs, id_rt           source register fields of the ID instruction
//   id_uses_rs/rt          ID instruction actually reads rs / rt
//   idex_memread, idex_rd  EX instruction is a load, and its destination
//   id_branch_taken        taken branch/jump resolved in ID
//   id_halt                HLT decoded in ID
//   exmem_mem_req          load/store in MEM starting an access
//   pc_wen                 PC write enable
//   ifid_wen, ifid_flush   IF/ID write enable and synchronous clear
//   idex_wen, idex_flush   ID/EX write enable and synchronous clear
//   exmem_wen, memwb_wen   EX/MEM and MEM/WB write enables
//   halted                 pipeline fully drained after HLT
//   stall_cycles           saturating count of non-halted cycles with pc_wen=0
// -----------------------------------------------------------------------------
module hazard_stall_ctrl #(
   parameter int MEM_LAT = 4,
   parameter int REG_W   = 4,
   parameter int DRAIN   = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [REG_W-1:0] id_rs,
   input  logic [REG_W-1:0] id_rt,
   input  logic             id_uses_rs,
   input  logic             id_uses_rt,
   input  logic             idex_memread,
   input  logic [REG_W-1:0] idex_rd,
   input  logic             id_branch_taken,
   input  logic             id_halt,
   input  logic             exmem_mem_req,
   output logic             pc_wen,
   output logic             ifid_wen,
   output logic             ifid_flush,
   output logic             idex_wen,
   output logic             idex_flush,
   output logic             exmem_wen,
   output logic             memwb_wen,
   output logic             halted,
   output logic [15:0]      stall_cycles
);

   localparam int CNT_W  = $clog2(MEM_LAT) + 1;
   localparam int DCNT_W = $clog2(DRAIN) + 1;
   localparam bit MEM_FREEZES = (MEM_LAT > 1);
   // Guarded so MEM_LAT=1 never produces a negative load value.
   localparam logic [CNT_W-1:0]  MEM_LOAD   = MEM_FREEZES ? CNT_W'(MEM_LAT - 2) : '0;
   localparam logic [DCNT_W-1:0] DRAIN_LOAD = DCNT_W'(DRAIN - 1);

   typedef enum logic [1:0] {
      ST_RUN,
      ST_DRAIN,
      ST_HALTED
   } state_t;

   state_t              state, state_nxt;
   logic                mem_busy, mem_busy_nxt;
   logic [CNT_W-1:0]    mem_cnt, mem_cnt_nxt;
   logic [DCNT_W-1:0]   drain_cnt, drain_cnt_nxt;
   logic [15:0]         stall_cnt;

   logic freeze;
   logic load_use;
   logic rs_hit, rt_hit;
   logic stall_inc;

   logic pc_wen_c, ifid_wen_c, ifid_flush_c, idex_wen_c, idex_flush_c;
   logic exmem_wen_c, memwb_wen_c, halted_c;

   // A load in EX writing r0 never creates a dependency, since r0 is constant.
   assign rs_hit   = id_uses_rs && (id_rs == idex_rd);
   assign rt_hit   = id_uses_rt && (id_rt == idex_rd);
   assign load_use = idex_memread && (idex_rd != '0) && (rs_hit || rt_hit);

   // The release cycle (busy with count 0) is deliberately not a freeze, and a
   // request seen then belongs to the departing access, so it cannot retrigger.
   assign freeze = (mem_busy && (mem_cnt != '0)) ||
                   (!mem_busy && exmem_mem_req && MEM_FREEZES);

   // Memory sub-FSM: counts the frozen cycles of one access independently of
   // the top-level state, so an access can overlap the HLT drain.
   always_comb begin
      mem_busy_nxt = mem_busy;
      mem_cnt_nxt  = mem_cnt;
      if (mem_busy) begin
         if (mem_cnt != '0) begin
            mem_cnt_nxt = mem_cnt - CNT_W'(1);
         end else begin
            mem_busy_nxt = 1'b0;
         end
      end else if (exmem_mem_req && MEM_FREEZES) begin
         mem_busy_nxt = 1'b1;
         mem_cnt_nxt  = MEM_LOAD;
      end
   end

   // Top-level next state and raw pipeline controls. Freeze overrides
   // everything except the parked HALTED state; inside RUN the priority is
   // load-use, then taken branch, then HLT.
   always_comb begin
      state_nxt     = state;
      drain_cnt_nxt = drain_cnt;
      pc_wen_c      = 1'b0;
      ifid_wen_c    = 1'b0;
      ifid_flush_c  = 1'b0;
      idex_wen_c    = 1'b0;
      idex_flush_c  = 1'b0;
      exmem_wen_c   = 1'b0;
      memwb_wen_c   = 1'b0;
      halted_c      = 1'b0;
      case (state)
         ST_RUN: begin
            if (!freeze) begin
               idex_wen_c  = 1'b1;
               exmem_wen_c = 1'b1;
               memwb_wen_c = 1'b1;
               if (load_use) begin
                  idex_flush_c = 1'b1;
               end else if (id_branch_taken) begin
                  pc_wen_c     = 1'b1;
                  ifid_wen_c   = 1'b1;
                  ifid_flush_c = 1'b1;
               end else if (id_halt) begin
                  idex_flush_c  = 1'b1;
                  state_nxt     = ST_DRAIN;
                  drain_cnt_nxt = DRAIN_LOAD;
               end else begin
                  pc_wen_c   = 1'b1;
                  ifid_wen_c = 1'b1;
               end
            end
         end
         ST_DRAIN: begin
            // Fetch stays stopped and bubbles follow HLT while older
            // instructions retire; the drain count only moves when unfrozen.
            if (!freeze) begin
               idex_wen_c   = 1'b1;
               idex_flush_c = 1'b1;
               exmem_wen_c  = 1'b1;
               memwb_wen_c  = 1'b1;
               if (drain_cnt == '0) begin
                  state_nxt = ST_HALTED;
               end else begin
                  drain_cnt_nxt = drain_cnt - DCNT_W'(1);
               end
            end
         end
         ST_HALTED: begin
            halted_c = 1'b1;
         end
         default: begin
            state_nxt = ST_RUN;
         end
      endcase
   end

   // Every output is held low while reset is asserted.
   assign pc_wen       = rst && pc_wen_c;
   assign ifid_wen     = rst && ifid_wen_c;
   assign ifid_flush   = rst && ifid_flush_c;
   assign idex_wen     = rst && idex_wen_c;
   assign idex_flush   = rst && idex_flush_c;
   assign exmem_wen    = rst && exmem_wen_c;
   assign memwb_wen    = rst && memwb_wen_c;
   assign halted       = rst && halted_c;
   assign stall_cycles = rst ? stall_cnt : 16'd0;

   assign stall_inc = rst && !pc_wen_c && (state != ST_HALTED);

   // State registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state     <= ST_RUN;
         mem_busy  <= 1'b0;
         mem_cnt   <= '0;
         drain_cnt <= '0;
         stall_cnt <= 16'd0;
      end else begin
         state     <= state_nxt;
         mem_busy  <= mem_busy_nxt;
         mem_cnt   <= mem_cnt_nxt;
         drain_cnt <= drain_cnt_nxt;
         if (stall_inc && (stall_cnt != 16'hFFFF)) begin
            stall_cnt <= stall_cnt + 16'd1;
         end
      end
   end

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// -----------------------------------------------------------------------------
// tb_hazard_stall_ctrl
//
// Scoreboard bench for hazard_stall_ctrl. Two instances share the stimulus:
// one with MEM_LAT=4 and one with MEM_LAT=1. For every driven cycle a
// behavioural reference model computes the expected controls and stall count
// and pushes them to a per-instance queue; they are popped and compared on the
// falling edge. Directed checks on top confirm the headline timings.
// -----------------------------------------------------------------------------
module tb_hazard_stall_ctrl;

   localparam int B_PC  = 7;
   localparam int B_IFW = 6;
   localparam int B_IFF = 5;
   localparam int B_IDW = 4;
   localparam int B_IDF = 3;
   localparam int B_HLT = 0;

   typedef struct packed {
      logic       rst;
      logic [3:0] rs;
      logic [3:0] rt;
      logic       urs;
      logic       urt;
      logic       memread;
      logic [3:0] rd;
      logic       br;
      logic       halt;
      logic       req;
   } stim_t;

   typedef struct {
      int st;      // 0 run, 1 drain, 2 halted
      bit busy;
      int cnt;
      int dcnt;
      int stall;
   } mstate_t;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] id_rs, id_rt, idex_rd;
   logic       id_uses_rs, id_uses_rt, idex_memread;
   logic       id_branch_taken, id_halt, exmem_mem_req;

   logic        pc_wen4, ifid_wen4, ifid_flush4, idex_wen4, idex_flush4;
   logic        exmem_wen4, memwb_wen4, halted4;
   logic [15:0] stall4;
   logic        pc_wen1, ifid_wen1, ifid_flush1, idex_wen1, idex_flush1;
   logic        exmem_wen1, memwb_wen1, halted1;
   logic [15:0] stall1;

   int vectors    = 0;
   int miscompares = 0;

   mstate_t m4, m1;
   logic [23:0] q4[$];
   logic [23:0] q1[$];
   logic [7:0]  smp4, smp1;
   logic [15:0] smp4_stall;

   always #5 clk = ~clk;

   hazard_stall_ctrl #(.MEM_LAT(4), .REG_W(4), .DRAIN(3)) dut4 (
      .clk(clk), .rst(rst),
      .id_rs(id_rs), .id_rt(id_rt),
      .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
      .idex_memread(idex_memread), .idex_rd(idex_rd),
      .id_branch_taken(id_branch_taken), .id_halt(id_halt),
      .exmem_mem_req(exmem_mem_req),
      .pc_wen(pc_wen4), .ifid_wen(ifid_wen4), .ifid_flush(ifid_flush4),
      .idex_wen(idex_wen4), .idex_flush(idex_flush4),
      .exmem_wen(exmem_wen4), .memwb_wen(memwb_wen4),
      .halted(halted4), .stall_cycles(stall4)
   );

   hazard_stall_ctrl #(.MEM_LAT(1), .REG_W(4), .DRAIN(3)) dut1 (
      .clk(clk), .rst(rst),
      .id_rs(id_rs), .id_rt(id_rt),
      .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
      .idex_memread(idex_memread), .idex_rd(idex_rd),
      .id_branch_taken(id_branch_taken), .id_halt(id_halt),
      .exmem_mem_req(exmem_mem_req),
      .pc_wen(pc_wen1), .ifid_wen(ifid_wen1), .ifid_flush(ifid_flush1),
      .idex_wen(idex_wen1), .idex_flush(idex_flush1),
      .exmem_wen(exmem_wen1), .memwb_wen(memwb_wen1),
      .halted(halted1), .stall_cycles(stall1)
   );

   // Counts one comparison and reports it when observed differs from expected.
   task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("[TB] FAIL %s: got %h, expected %h at %0t", tag, act, exp, $time);
      end
   endtask

   function automatic stim_t idle();
      stim_t s;
      s = '0;
      s.rst = 1'b1;
      return s;
   endfunction

   // Reference model of one cycle. Output packing:
   // {pc_wen, ifid_wen, ifid_flush, idex_wen, idex_flush, exmem_wen, memwb_wen, halted}
   function automatic void modelStep(input mstate_t cur, input stim_t s, input int lat,
                                     output logic [23:0] exp, output mstate_t nxt);
      bit         frz, lu;
      logic [7:0] o;
      nxt = cur;
      frz = (cur.busy && cur.cnt != 0) || (!cur.busy && s.req && lat > 1);
      lu  = s.memread && s.rd != 0 &&
            ((s.urs && s.rs == s.rd) || (s.urt && s.rt == s.rd));
      if (!s.rst) begin
         nxt.st = 0; nxt.busy = 0; nxt.cnt = 0; nxt.dcnt = 0; nxt.stall = 0;
         exp = '0;
         return;
      end
      if (cur.st == 2)             o = 8'b0000_0001;
      else if (frz)                o = 8'b0000_0000;
      else if (cur.st == 1)        o = 8'b0001_1110;
      else if (lu)                 o = 8'b0001_1110;
      else if (s.br)               o = 8'b1111_0110;
      else if (s.halt)             o = 8'b0001_1110;
      else                         o = 8'b1101_0110;
      exp = {o, cur.stall[15:0]};
      if (cur.busy) begin
         if (cur.cnt != 0) nxt.cnt = cur.cnt - 1;
         else              nxt.busy = 0;
      end else if (s.req && lat > 1) begin
         nxt.busy = 1;
         nxt.cnt  = lat - 2;
      end
      if (!frz && cur.st == 0 && !lu && !s.br && s.halt) begin
         nxt.st   = 1;
         nxt.dcnt = 2;
      end else if (!frz && cur.st == 1) begin
         if (cur.dcnt == 0) nxt.st = 2;
         else               nxt.dcnt = cur.dcnt - 1;
      end
      if (!o[7] && cur.st != 2 && cur.stall < 65535) nxt.stall = cur.stall + 1;
   endfunction

   // Drives one cycle of stimulus just after the rising edge, queues the
   // model's expectation, then compares on the falling edge.
   task automatic applyStimulus(input stim_t s);
      logic [23:0] e4, e1, x4, x1;
      mstate_t     n4, n1;
      rst = s.rst; id_rs = s.rs; id_rt = s.rt;
      id_uses_rs = s.urs; id_uses_rt = s.urt;
      idex_memread = s.memread; idex_rd = s.rd;
      id_branch_taken = s.br; id_halt = s.halt; exmem_mem_req = s.req;
      modelStep(m4, s, 4, e4, n4);
      modelStep(m1, s, 1, e1, n1);
      q4.push_back(e4);
      q1.push_back(e1);
      m4 = n4;
      m1 = n1;
      @(negedge clk);
      smp4 = {pc_wen4, ifid_wen4, ifid_flush4, idex_wen4, idex_flush4,
              exmem_wen4, memwb_wen4, halted4};
      smp1 = {pc_wen1, ifid_wen1, ifid_flush1, idex_wen1, idex_flush1,
              exmem_wen1, memwb_wen1, halted1};
      smp4_stall = stall4;
      x4 = q4.pop_front();
      x1 = q1.pop_front();
      checkOutput("lat4_ctrl",  {24'd0, smp4}, {24'd0, x4[23:16]});
      checkOutput("lat4_stall", {16'd0, stall4}, {16'd0, x4[15:0]});
      checkOutput("lat1_ctrl",  {24'd0, smp1}, {24'd0, x1[23:16]});
      checkOutput("lat1_stall", {16'd0, stall1}, {16'd0, x1[15:0]});
      @(posedge clk);
      #1;
   endtask

   // Main sequence of directed scenarios plus a short randomised stretch.
   initial begin
      stim_t s;
      int    cnt4, cnt1, rise4, rise1, pc_hi;
      m4 = '{0, 0, 0, 0, 0};
      m1 = '{0, 0, 0, 0, 0};
      s = idle();
      s.rst = 1'b0;
      rst = 1'b0; id_rs = '0; id_rt = '0; id_uses_rs = 0; id_uses_rt = 0;
      idex_memread = 0; idex_rd = '0; id_branch_taken = 0; id_halt = 0; exmem_mem_req = 0;
      @(posedge clk);
      #1;

      // Reset held with a pending memory request: everything low.
      s.req = 1'b1;
      applyStimulus(s);
      checkOutput("reset_outputs", {24'd0, smp4}, 32'd0);
      applyStimulus(s);
      applyStimulus(idle());
      checkOutput("post_reset_pc_wen", {31'd0, smp4[B_PC]}, 32'd1);
      checkOutput("post_reset_ifid_wen", {31'd0, smp4[B_IFW]}, 32'd1);
      checkOutput("post_reset_stall", {16'd0, smp4_stall}, 32'd0);

      // Load-use on rs: exactly one bubble, one stall cycle counted.
      s = idle(); s.memread = 1; s.rd = 4'd3; s.rs = 4'd3; s.urs = 1;
      applyStimulus(s);
      checkOutput("lu_pc_wen", {31'd0, smp4[B_PC]}, 32'd0);
      checkOutput("lu_idex_flush", {31'd0, smp4[B_IDF]}, 32'd1);
      applyStimulus(idle());
      checkOutput("lu_one_bubble", {31'd0, smp4[B_PC]}, 32'd1);
      checkOutput("lu_stall_count", {16'd0, smp4_stall}, 32'd1);
      s.rd = 4'd0; s.rs = 4'd0;
      applyStimulus(s);
      checkOutput("lu_r0_no_stall", {31'd0, smp4[B_PC]}, 32'd1);

      // Memory freeze: request held for four cycles.
      cnt4 = 0; cnt1 = 0;
      for (int i = 0; i < 4; i++) begin
         s = idle(); s.req = 1;
         applyStimulus(s);
         if (!smp4[B_PC]) cnt4++;
         if (!smp1[B_PC]) cnt1++;
      end
      checkOutput("freeze_cycles_lat4", cnt4, 32'd3);
      checkOutput("freeze_cycles_lat1", cnt1, 32'd0);
      applyStimulus(idle());
      checkOutput("no_second_freeze", {31'd0, smp4[B_PC]}, 32'd1);

      // Load-use together with a taken branch: the branch waits a cycle.
      s = idle(); s.memread = 1; s.rd = 4'd5; s.rt = 4'd5; s.urt = 1; s.br = 1;
      applyStimulus(s);
      checkOutput("lu_br_idex_flush", {31'd0, smp4[B_IDF]}, 32'd1);
      checkOutput("lu_br_ifid_flush", {31'd0, smp4[B_IFF]}, 32'd0);
      s = idle(); s.br = 1;
      applyStimulus(s);
      checkOutput("br_ifid_flush", {31'd0, smp4[B_IFF]}, 32'd1);
      checkOutput("br_pc_wen", {31'd0, smp4[B_PC]}, 32'd1);

      // Randomised traffic without HLT, including occasional resets.
      for (int i = 0; i < 60; i++) begin
         s = idle();
         s.rst     = ($urandom_range(0, 19) != 0);
         s.memread = 1'($urandom_range(0, 1));
         s.rd      = 4'($urandom_range(0, 3));
         s.rs      = 4'($urandom_range(0, 3));
         s.rt      = 4'($urandom_range(0, 3));
         s.urs     = 1'($urandom_range(0, 1));
         s.urt     = 1'($urandom_range(0, 1));
         s.br      = ($urandom_range(0, 3) == 0);
         s.req     = ($urandom_range(0, 5) == 0);
         applyStimulus(s);
      end

      // Reset in the middle of a freeze clears the memory sub-FSM.
      for (int i = 0; i < 5; i++) applyStimulus(idle());
      s = idle(); s.req = 1;
      applyStimulus(s);
      applyStimulus(idle());
      s = idle(); s.rst = 0;
      applyStimulus(s);
      applyStimulus(idle());
      checkOutput("mid_freeze_reset_pc", {31'd0, smp4[B_PC]}, 32'd1);
      checkOutput("mid_freeze_reset_halted", {31'd0, smp4[B_HLT]}, 32'd0);

      // HLT followed by an access on the first drain cycle.
      for (int i = 0; i < 5; i++) applyStimulus(idle());
      s = idle(); s.halt = 1;
      applyStimulus(s);
      checkOutput("hlt_pc_wen", {31'd0, smp4[B_PC]}, 32'd0);
      rise4 = 20; rise1 = 20; pc_hi = 0;
      for (int k = 1; k <= 20; k++) begin
         s = idle();
         if (k == 1) s.req = 1;
         if (k > 8) begin s.br = 1; s.memread = 1; s.rd = 4'd2; s.rs = 4'd2; s.urs = 1; end
         applyStimulus(s);
         if (smp4[B_HLT] && rise4 == 20) rise4 = k;
         if (smp1[B_HLT] && rise1 == 20) rise1 = k;
         if (smp4[B_PC]) pc_hi++;
      end
      checkOutput("drain_cycles_lat4", rise4 - 1, 32'd6);
      checkOutput("drain_cycles_lat1", rise1 - 1, 32'd3);
      checkOutput("pc_held_while_halting", pc_hi, 32'd0);

      // Only reset leaves HALTED.
      s = idle(); s.rst = 0;
      applyStimulus(s);
      applyStimulus(idle());
      checkOutput("unhalt_halted", {31'd0, smp4[B_HLT]}, 32'd0);
      checkOutput("unhalt_pc_wen", {31'd0, smp4[B_PC]}, 32'd1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
